ff_bypass_bank: RTL and testbench



---
 rtl/ff_bypass_bank.sv | 130 +++++++++++++
 tb/tb_ff_bypass_bank.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ff_bypass_bank.sv
// ff_bypass_bank
//
// Lane-configurable register bank. Each of WIDTH lanes either passes data
// straight through or delays it by 1..DEPTH clocked stages. The stages have a
// synchronous global reset, a per-lane local reset and a per-lane clock enable,
// and can be stitched into one scan chain. Per-lane latency lives in
// configuration bits written through the bl/wl port.
//
// Optional feature macro: FF_BYPASS_BANK_SCAN_EN
//   defined   : scan_en shifts the chain, scan_mode forces Q to the last stage
//               of each lane and blocks configuration writes, SO is the chain end.
//   undefined : scan_en, scan_mode and SI are ignored and SO is tied to 0.
//
// Ports
//   ff_bypass_bank_C  : fabric clock, rising edge
//   global_resetn     : synchronous active-low clear of all data stages
//   scan_en           : 1 = shift the scan chain by one position
//   scan_mode         : 1 = test mode (Q from last stages, config writes blocked)
//   ff_bypass_bank_D  : lane data in [WIDTH]
//   ff_bypass_bank_SI : scan chain in
//   ff_bypass_bank_R  : per-lane synchronous local reset, active-high [WIDTH]
//   ff_bypass_bank_E  : per-lane clock enable, active-high [WIDTH]
//   bl                : configuration bit-line data [WIDTH*SELW]
//   wl                : configuration word-line strobes [WIDTH*SELW]
//   ff_bypass_bank_SO : scan chain out (registered)
//   ff_bypass_bank_Q  : lane data out [WIDTH]
module ff_bypass_bank #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 2,
  localparam int SELW  = $clog2(DEPTH + 1)
) (
  input  logic                    ff_bypass_bank_C,
  input  logic                    global_resetn,
  input  logic                    scan_en,
  input  logic                    scan_mode,
  input  logic [WIDTH-1:0]        ff_bypass_bank_D,
  input  logic                    ff_bypass_bank_SI,
  input  logic [WIDTH-1:0]        ff_bypass_bank_R,
  input  logic [WIDTH-1:0]        ff_bypass_bank_E,
  input  logic [WIDTH*SELW-1:0]   bl,
  input  logic [WIDTH*SELW-1:0]   wl,
  output logic                    ff_bypass_bank_SO,
  output logic [WIDTH-1:0]        ff_bypass_bank_Q
);

  // Stage s[i][j] lives at flat index i*DEPTH + j, which is also its scan
  // chain position counted from SI.
  localparam int NST = WIDTH * DEPTH;

  logic [NST-1:0]        s_q, s_d;
  logic [WIDTH*SELW-1:0] cfg_q, cfg_d;
  logic [WIDTH*SELW-1:0] cfg_wr;
  logic                  scan_shift;
  logic                  scan_test;

  // Configured latency values above DEPTH behave as DEPTH.
  function automatic logic [SELW-1:0] sat_lat(input logic [SELW-1:0] c);
    if (c > SELW'(DEPTH)) return SELW'(DEPTH);
    return c;
  endfunction

`ifdef FF_BYPASS_BANK_SCAN_EN
  assign scan_shift        = scan_en;
  assign scan_test         = scan_mode;
  assign ff_bypass_bank_SO = s_q[NST-1];
`else
  assign scan_shift        = 1'b0;
  assign scan_test         = 1'b0;
  assign ff_bypass_bank_SO = 1'b0;
  logic unused_scan;
  assign unused_scan = &{1'b0, scan_en, scan_mode};
`endif

  // Configuration bits: per-bit write strobe, dropped in test mode, untouched
  // by any reset.
  assign cfg_wr = scan_test ? '0 : wl;
  assign cfg_d  = (cfg_q & ~cfg_wr) | (bl & cfg_wr);

  always_ff @(posedge ff_bypass_bank_C) begin
    cfg_q <= cfg_d;
  end

  // Stage next-state: scan shift overrides local reset and enable. All DEPTH
  // stages of an enabled lane shift regardless of its latency, so a latency
  // change on the fly exposes data already in flight.
  always_comb begin
    s_d = s_q;
    if (scan_shift) begin
      s_d[0] = ff_bypass_bank_SI;
      for (int k = 1; k < NST; k++) s_d[k] = s_q[k-1];
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (ff_bypass_bank_R[i]) begin
          s_d[i*DEPTH +: DEPTH] = '0;
        end else if (ff_bypass_bank_E[i]) begin
          s_d[i*DEPTH] = ff_bypass_bank_D[i];
          for (int j = 1; j < DEPTH; j++) s_d[i*DEPTH + j] = s_q[i*DEPTH + j - 1];
        end
      end
    end
  end

  always_ff @(posedge ff_bypass_bank_C) begin
    if (!global_resetn) s_q <= '0;
    else                s_q <= s_d;
  end

  // Output select per lane: latency 0 is a combinational bypass, latency L
  // taps stage L-1, test mode always taps the last stage.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic [SELW-1:0] lat;
    logic            lane_q;

    assign lat = sat_lat(cfg_q[i*SELW +: SELW]);

    always_comb begin
      lane_q = ff_bypass_bank_D[i];
      if (scan_test) begin
        lane_q = s_q[i*DEPTH + DEPTH - 1];
      end else begin
        for (int j = 0; j < DEPTH; j++) begin
          if (int'(lat) == j + 1) lane_q = s_q[i*DEPTH + j];
        end
      end
    end

    assign ff_bypass_bank_Q[i] = lane_q;
  end

endmodule

// File: tb/tb_ff_bypass_bank.sv
module tb_ff_bypass_bank;
  localparam int W  = 4;
  localparam int DP = 2;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          resetn, scan_en, scan_mode, si, so;
  logic [W-1:0]  d, r, e, q;
  logic [W*SW-1:0] bl, wl;
  int            tests = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  ff_bypass_bank #(.WIDTH(W), .DEPTH(DP)) dut (
    .ff_bypass_bank_C (clk),
    .global_resetn    (resetn),
    .scan_en          (scan_en),
    .scan_mode        (scan_mode),
    .ff_bypass_bank_D (d),
    .ff_bypass_bank_SI(si),
    .ff_bypass_bank_R (r),
    .ff_bypass_bank_E (e),
    .bl               (bl),
    .wl               (wl),
    .ff_bypass_bank_SO(so),
    .ff_bypass_bank_Q (q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] pat;
    resetn = 1'b0; scan_en = 1'b0; scan_mode = 1'b0; si = 1'b0;
    d = '0; r = '0; e = '0;
    // lane0=2, lane1=1, lane2=0, lane3=2
    bl = 8'b10_00_01_10; wl = 8'hFF;
    tick();

    // Reset state and first latencies
    wl = '0; resetn = 1'b1; d = 4'b1111; #1;
    chk("rst_q", q, 4'b0100);
    chk("rst_so", {3'b0, so}, 4'b0000);
    e = 4'hF; tick();
    chk("lat_edge1", q, 4'b0110);
    tick();
    chk("lat_edge2", q, 4'b1111);

    // Saturation: lane0 cfg=3 acts as latency 2
    bl = 8'h03; wl = 8'h03; d = '0; e = '0; tick();
    wl = '0;
    chk("sat_hold", q, 4'b1011);
    e = 4'hF; tick();
    chk("sat_edge1", q, 4'b1001);
    tick();
    chk("sat_edge2", q, 4'b0000);

    // Stall on lane0
    d = 4'b0001; tick();
    chk("stall_in", q, 4'b0000);
    d = '0; e = 4'b1110;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_hold", {3'b0, q[0]}, 4'b0000);
    end
    e = 4'hF; tick();
    chk("stall_out", q, 4'b0001);
    tick();
    chk("stall_done", q, 4'b0000);

    // Local reset wins over enable, other lanes unaffected
    d = 4'hF; tick(); tick();
    chk("fill", q, 4'b1111);
    r = 4'b0001; tick();
    chk("lrst", q, 4'b1110);
    r = '0; d = '0; tick();
    chk("lrst_after", q, 4'b1000);

    // Config write on lane2 bit0: bypass -> stage 0
    e = '0; d = 4'b0100; #1;
    chk("cfg_pre", q, 4'b1100);
    bl = 8'h10; wl = 8'h10; tick();
    wl = '0;
    chk("cfg_wr", q, 4'b1000);

`ifdef FF_BYPASS_BANK_SCAN_EN
    // Reset wins over scan shift
    resetn = 1'b0; scan_en = 1'b1; si = 1'b1; tick();
    resetn = 1'b1;
    chk("rst_scan_so", {3'b0, so}, 4'b0000);

    // Shift 10110010 MSB first, E=0 and R=1 ignored
    pat = 8'b10110010; e = '0; r = 4'hF;
    for (int k = 0; k < 8; k++) begin
      si = pat[7-k]; tick();
      if (k < 7) chk("scan_so_empty", {3'b0, so}, 4'b0000);
    end
    chk("scan_so_0", {3'b0, so}, {3'b0, pat[7]});
    scan_mode = 1'b1; #1;
    chk("scan_mode_q", q, 4'b1101);
    scan_mode = 1'b0;
    for (int m = 1; m < 8; m++) begin
      si = 1'b0; tick();
      chk("scan_so_seq", {3'b0, so}, {3'b0, pat[7-m]});
    end

    // Config write blocked in test mode (chain is all zero now)
    scan_en = 1'b0; r = '0; scan_mode = 1'b1; bl = '0; wl = 8'hFF; tick();
    wl = '0; scan_mode = 1'b0; d = 4'hF; #1;
    chk("cfg_block", q, 4'b0000);

    // Reset during shift clears the chain
    scan_en = 1'b1; si = 1'b1; tick(); tick();
    resetn = 1'b0; tick();
    resetn = 1'b1; scan_mode = 1'b1; #1;
    chk("rst_scan_q", q, 4'b0000);
    chk("rst_scan_so2", {3'b0, so}, 4'b0000);
`else
    // Scan controls ignored, capture continues, SO stays 0
    scan_en = 1'b1; scan_mode = 1'b1; e = 4'hF; d = 4'hF; si = 1'b1; tick();
    chk("noscan_q1", q, 4'b0110);
    chk("noscan_so1", {3'b0, so}, 4'b0000);
    si = 1'b0; d = '0; tick();
    chk("noscan_q2", q, 4'b1001);
    chk("noscan_so2", {3'b0, so}, 4'b0000);
    // Config writes not blocked: lane1 -> bypass
    bl = '0; wl = 8'h0C; d = 4'b0010; si = 1'b1; tick();
    wl = '0; d = '0; #1;
    chk("noscan_cfg", q, 4'b0000);
    chk("noscan_so3", {3'b0, so}, 4'b0000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
